// File: rtl/mac_pkg.sv
// ============================================================================
// Module      : mac_pkg
// Description : Shared types, constants and helpers for the MAC accumulator.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package mac_pkg;

    localparam int PROD_W    = 32;
    localparam int MAX_ACC_W = 64;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ACC  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    // Widest supported sign extension; callers narrow with a size cast.
    function automatic logic [MAX_ACC_W-1:0] sext_prod(input logic [PROD_W-1:0] p);
        return {{(MAX_ACC_W-PROD_W){p[PROD_W-1]}}, p};
    endfunction

    function automatic logic [MAX_ACC_W-1:0] sat_max(input int acc_w);
        return (MAX_ACC_W'(1) << (acc_w - 1)) - MAX_ACC_W'(1);
    endfunction

    function automatic logic [MAX_ACC_W-1:0] sat_min(input int acc_w);
        return ~sat_max(acc_w);
    endfunction

endpackage

`default_nettype wire

// File: rtl/mac_acc_add.sv
// ============================================================================
// Module      : mac_acc_add
// Description : ACC_W+1 bit accumulate adder with signed overflow detection.
//               Saturation enabled by macro MAC_ACC_SAT_EN, wrap otherwise.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module mac_acc_add
    import mac_pkg::*;
#(
    parameter int ACC_W = 40
) (
    input  logic              i_frame_open,
    input  logic [ACC_W-1:0]  i_acc,
    input  logic [PROD_W-1:0] i_product,
    output logic [ACC_W-1:0]  o_result,
    output logic              o_ovf
);

    localparam logic [ACC_W-1:0] c_sat_max = ACC_W'(sat_max(ACC_W));
    localparam logic [ACC_W-1:0] c_sat_min = ACC_W'(sat_min(ACC_W));

    logic [ACC_W-1:0] w_base;
    logic [ACC_W-1:0] w_ext;
    logic [ACC_W:0]   w_sum;

    always_comb begin
        w_base = i_frame_open ? i_acc : '0;
        w_ext  = ACC_W'(sext_prod(i_product));
        w_sum  = {w_base[ACC_W-1], w_base} + {w_ext[ACC_W-1], w_ext};
        o_ovf  = w_sum[ACC_W] ^ w_sum[ACC_W-1];
`ifdef MAC_ACC_SAT_EN
        // The extra top bit carries the true sign of the unbounded sum.
        if (o_ovf) begin
            o_result = w_sum[ACC_W] ? c_sat_min : c_sat_max;
        end else begin
            o_result = w_sum[ACC_W-1:0];
        end
`else
        o_result = w_sum[ACC_W-1:0];
`endif
    end

endmodule

`default_nettype wire

// File: rtl/mac_acc_tc_32_40.sv
// ============================================================================
// Module      : mac_acc_tc_32_40
// Description : Frame accumulator for signed 32-bit products with valid/ready
//               result output. Optional saturation via macro MAC_ACC_SAT_EN.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module mac_acc_tc_32_40
    import mac_pkg::*;
#(
    parameter  int ACC_W     = 40,
    parameter  int MAX_TERMS = 256,
    localparam int CNT_W     = $clog2(MAX_TERMS + 1)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [PROD_W-1:0] in_product,
    input  logic              in_last,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [ACC_W-1:0]  out_acc,
    output logic [CNT_W-1:0]  out_terms,
    output logic              out_trunc,
    output logic              out_ovf
);

    state_t           r_state;
    logic [ACC_W-1:0] r_acc;
    logic [CNT_W-1:0] r_cnt;
    logic             r_ovf;
    logic             r_out_valid;
    logic [ACC_W-1:0] r_out_acc;
    logic [CNT_W-1:0] r_out_terms;
    logic             r_out_trunc;
    logic             r_out_ovf;

    logic             w_frame_open;
    logic             w_accept;
    logic             w_close;
    logic             w_add_ovf;
    logic             w_ovf_any;
    logic [ACC_W-1:0] w_sum;
    logic [CNT_W-1:0] w_cnt_next;

    assign w_frame_open = (r_state == ST_ACC);
    assign in_ready     = !r_out_valid || out_ready;
    assign w_accept     = in_valid && in_ready;
    assign w_cnt_next   = (w_frame_open ? r_cnt : '0) + CNT_W'(1);
    assign w_close      = in_last || (w_cnt_next == CNT_W'(MAX_TERMS));
    assign w_ovf_any    = (w_frame_open && r_ovf) || w_add_ovf;

    mac_acc_add #(
        .ACC_W (ACC_W)
    ) u_add (
        .i_frame_open (w_frame_open),
        .i_acc        (r_acc),
        .i_product    (in_product),
        .o_result     (w_sum),
        .o_ovf        (w_add_ovf)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= ST_IDLE;
            r_acc       <= '0;
            r_cnt       <= '0;
            r_ovf       <= 1'b0;
            r_out_valid <= 1'b0;
            r_out_acc   <= '0;
            r_out_terms <= '0;
            r_out_trunc <= 1'b0;
            r_out_ovf   <= 1'b0;
        end else if (w_accept) begin
            // An accept in DONE implies out_ready, so the held result is gone.
            if (w_close) begin
                r_out_acc   <= w_sum;
                r_out_terms <= w_cnt_next;
                r_out_trunc <= !in_last;
                r_out_ovf   <= w_ovf_any;
                r_out_valid <= 1'b1;
                r_state     <= ST_DONE;
                r_acc       <= '0;
                r_cnt       <= '0;
                r_ovf       <= 1'b0;
            end else begin
                r_acc       <= w_sum;
                r_cnt       <= w_cnt_next;
                r_ovf       <= w_ovf_any;
                r_out_valid <= 1'b0;
                r_state     <= ST_ACC;
            end
        end else if (r_state == ST_DONE && out_ready) begin
            r_out_valid <= 1'b0;
            r_state     <= ST_IDLE;
        end
    end

    assign out_valid = r_out_valid;
    assign out_acc   = r_out_acc;
    assign out_terms = r_out_terms;
    assign out_trunc = r_out_trunc;
    assign out_ovf   = r_out_ovf;

endmodule

`default_nettype wire
